// File: rtl/axi_slave_if.sv
// AXI responder that terminates one write or read burst at a time and turns
// every beat into a single-word request on a simple valid/ready backend port.
module axi_slave_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 16
) (
    input  logic                          axi_clk_in,
    input  logic                          axi_rst_in,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_awaddr_in,
    input  logic [1:0]                    axi_awburst_in,
    input  logic [7:0]                    axi_awlen_in,
    input  logic [2:0]                    axi_awsize_in,
    input  logic [AXI_ID_WIDTH-1:0]       axi_awid_in,
    input  logic                          axi_awvalid_in,
    output logic                          axi_awready_out,
    input  logic [AXI_DATA_WIDTH-1:0]     axi_wdata_in,
    input  logic [AXI_DATA_WIDTH/8-1:0]   axi_wstrb_in,
    input  logic                          axi_wlast_in,
    input  logic                          axi_wvalid_in,
    output logic                          axi_wready_out,
    output logic [AXI_ID_WIDTH-1:0]       axi_bid_out,
    output logic [1:0]                    axi_bresp_out,
    output logic                          axi_bvalid_out,
    input  logic                          axi_bready_in,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_araddr_in,
    input  logic [1:0]                    axi_arburst_in,
    input  logic [7:0]                    axi_arlen_in,
    input  logic [2:0]                    axi_arsize_in,
    input  logic [AXI_ID_WIDTH-1:0]       axi_arid_in,
    input  logic                          axi_arvalid_in,
    output logic                          axi_arready_out,
    output logic [AXI_DATA_WIDTH-1:0]     axi_rdata_out,
    output logic [AXI_ID_WIDTH-1:0]       axi_rid_out,
    output logic [1:0]                    axi_rresp_out,
    output logic                          axi_rlast_out,
    output logic                          axi_rvalid_out,
    input  logic                          axi_rready_in,
    output logic [AXI_ADDR_WIDTH-1:0]     other_addr_out,
    output logic                          other_write_out,
    output logic [AXI_DATA_WIDTH-1:0]     other_wdata_out,
    output logic [AXI_DATA_WIDTH/8-1:0]   other_strb_out,
    output logic                          other_valid_out,
    input  logic                          other_ready_in,
    input  logic [AXI_DATA_WIDTH-1:0]     other_rdata_in,
    input  logic                          other_error_in
);

    localparam int NB = AXI_DATA_WIDTH / 8;
    localparam logic [31:0] NB_BYTES = 32'(NB);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_ONE = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        WDATA = 5'b00010,
        BRESP = 5'b00100,
        RADDR = 5'b01000,
        RDATA = 5'b10000
    } state_t;

    state_t                        state_r, state_s;
    logic                          prio_w_r;
    logic [AXI_ID_WIDTH-1:0]       id_r;
    logic [AXI_ADDR_WIDTH-1:0]     addr_r;
    logic [7:0]                    len_r;
    logic [2:0]                    size_r;
    logic [1:0]                    burst_r;
    logic                          illegal_r;
    logic [7:0]                    cnt_r;
    logic                          err_r;
    logic [AXI_DATA_WIDTH-1:0]     rdata_r;
    logic [AXI_ID_WIDTH-1:0]       rid_r;
    logic [1:0]                    rresp_r;
    logic                          rlast_r;
    logic                          rvalid_r;

    logic                          awready_s, arready_s, wready_s, bvalid_s;
    logic                          other_valid_s, other_write_s, w_beat_s, rd_take_s;
    logic [AXI_ADDR_WIDTH-1:0]     other_addr_s, next_addr_s;
    logic [AXI_DATA_WIDTH-1:0]     other_wdata_s;
    logic [NB-1:0]                 other_strb_s;
    logic                          last_beat_s;

    function automatic logic is_illegal(input logic [1:0] burst, input logic [7:0] len,
                                        input logic [2:0] size);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == 2'b11) || ((32'd1 << size) > NB_BYTES) ||
               ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    // WRAP keeps the bits above the wrap boundary and lets only the low bits roll over
    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                                            input logic [7:0] len,
                                                            input logic [2:0] size,
                                                            input logic [1:0] burst);
        logic [AXI_ADDR_WIDTH-1:0] bytes, mask, nxt;
        bytes = ADDR_ONE << size;
        mask  = ((AXI_ADDR_WIDTH'(len) + ADDR_ONE) << size) - ADDR_ONE;
        case (burst)
            2'b00:   nxt = addr;
            2'b01:   nxt = addr + bytes;
            2'b10:   nxt = (addr & ~mask) | ((addr + bytes) & mask);
            default: nxt = addr;
        endcase
        return nxt;
    endfunction

    assign next_addr_s = next_addr(addr_r, len_r, size_r, burst_r);
    assign last_beat_s = (cnt_r == len_r);

    // Next-state decode plus the combinational handshake and backend outputs
    always_comb begin
        state_s       = state_r;
        awready_s     = 1'b0;
        arready_s     = 1'b0;
        wready_s      = 1'b0;
        bvalid_s      = 1'b0;
        other_valid_s = 1'b0;
        other_write_s = 1'b0;
        other_addr_s  = {AXI_ADDR_WIDTH{1'b0}};
        other_wdata_s = {AXI_DATA_WIDTH{1'b0}};
        other_strb_s  = {NB{1'b0}};
        w_beat_s      = 1'b0;
        rd_take_s     = 1'b0;
        case (state_r)
            IDLE: begin
                awready_s = !axi_rst_in && axi_awvalid_in && (!axi_arvalid_in || prio_w_r);
                arready_s = !axi_rst_in && axi_arvalid_in && (!axi_awvalid_in || !prio_w_r);
                if (awready_s) begin
                    state_s = WDATA;
                end else if (arready_s) begin
                    state_s = RADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            WDATA: begin
                other_valid_s = axi_wvalid_in && !illegal_r;
                other_write_s = 1'b1;
                other_addr_s  = addr_r;
                other_wdata_s = axi_wdata_in;
                other_strb_s  = axi_wstrb_in;
                wready_s      = illegal_r ? 1'b1 : other_ready_in;
                w_beat_s      = axi_wvalid_in && wready_s;
                if (w_beat_s && last_beat_s) begin
                    state_s = BRESP;
                end else begin
                    state_s = WDATA;
                end
            end
            BRESP: begin
                bvalid_s = 1'b1;
                if (axi_bready_in) begin
                    state_s = IDLE;
                end else begin
                    state_s = BRESP;
                end
            end
            RADDR: begin
                other_valid_s = !illegal_r;
                other_addr_s  = addr_r;
                rd_take_s     = illegal_r || other_ready_in;
                if (rd_take_s) begin
                    state_s = RDATA;
                end else begin
                    state_s = RADDR;
                end
            end
            RDATA: begin
                if (axi_rready_in) begin
                    state_s = rlast_r ? IDLE : RADDR;
                end else begin
                    state_s = RDATA;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and round-robin write/read priority
    always_ff @(posedge axi_clk_in or posedge axi_rst_in) begin
        if (axi_rst_in) begin
            state_r  <= IDLE;
            prio_w_r <= 1'b1;
        end else begin
            state_r <= state_s;
            if (awready_s || arready_s) begin
                prio_w_r <= !prio_w_r;
            end
        end
    end

    // Burst context: captured request, beat counter, current address, sticky error
    always_ff @(posedge axi_clk_in or posedge axi_rst_in) begin
        if (axi_rst_in) begin
            id_r      <= {AXI_ID_WIDTH{1'b0}};
            addr_r    <= {AXI_ADDR_WIDTH{1'b0}};
            len_r     <= 8'd0;
            size_r    <= 3'd0;
            burst_r   <= 2'd0;
            illegal_r <= 1'b0;
            cnt_r     <= 8'd0;
            err_r     <= 1'b0;
        end else if (awready_s) begin
            id_r      <= axi_awid_in;
            addr_r    <= axi_awaddr_in;
            len_r     <= axi_awlen_in;
            size_r    <= axi_awsize_in;
            burst_r   <= axi_awburst_in;
            illegal_r <= is_illegal(axi_awburst_in, axi_awlen_in, axi_awsize_in);
            err_r     <= is_illegal(axi_awburst_in, axi_awlen_in, axi_awsize_in);
            cnt_r     <= 8'd0;
        end else if (arready_s) begin
            id_r      <= axi_arid_in;
            addr_r    <= axi_araddr_in;
            len_r     <= axi_arlen_in;
            size_r    <= axi_arsize_in;
            burst_r   <= axi_arburst_in;
            illegal_r <= is_illegal(axi_arburst_in, axi_arlen_in, axi_arsize_in);
            err_r     <= 1'b0;
            cnt_r     <= 8'd0;
        end else if (w_beat_s) begin
            cnt_r  <= cnt_r + 8'd1;
            addr_r <= next_addr_s;
            err_r  <= err_r | (other_error_in && !illegal_r) | (axi_wlast_in != last_beat_s);
        end else if ((state_r == RDATA) && axi_rready_in) begin
            cnt_r  <= cnt_r + 8'd1;
            addr_r <= next_addr_s;
        end
    end

    // Read-data channel registers, held stable until the master takes the beat
    always_ff @(posedge axi_clk_in or posedge axi_rst_in) begin
        if (axi_rst_in) begin
            rdata_r  <= {AXI_DATA_WIDTH{1'b0}};
            rid_r    <= {AXI_ID_WIDTH{1'b0}};
            rresp_r  <= 2'b00;
            rlast_r  <= 1'b0;
            rvalid_r <= 1'b0;
        end else if (rd_take_s) begin
            rdata_r  <= illegal_r ? {AXI_DATA_WIDTH{1'b0}} : other_rdata_in;
            rresp_r  <= (illegal_r || other_error_in) ? 2'b10 : 2'b00;
            rid_r    <= id_r;
            rlast_r  <= last_beat_s;
            rvalid_r <= 1'b1;
        end else if ((state_r == RDATA) && axi_rready_in) begin
            rvalid_r <= 1'b0;
            rlast_r  <= 1'b0;
            rresp_r  <= 2'b00;
        end
    end

    assign axi_awready_out = awready_s;
    assign axi_arready_out = arready_s;
    assign axi_wready_out  = wready_s;
    assign axi_bvalid_out  = bvalid_s;
    assign axi_bid_out     = bvalid_s ? id_r : {AXI_ID_WIDTH{1'b0}};
    assign axi_bresp_out   = (bvalid_s && err_r) ? 2'b10 : 2'b00;
    assign axi_rdata_out   = rdata_r;
    assign axi_rid_out     = rid_r;
    assign axi_rresp_out   = rresp_r;
    assign axi_rlast_out   = rlast_r;
    assign axi_rvalid_out  = rvalid_r;
    assign other_addr_out  = other_addr_s;
    assign other_write_out = other_write_s;
    assign other_wdata_out = other_wdata_s;
    assign other_strb_out  = other_strb_s;
    assign other_valid_out = other_valid_s;

endmodule

// File: tb/tb_axi_slave_if.sv
// Randomized scoreboard bench for axi_slave_if: tasks queue expected backend
// accesses and B/R responses, a negedge monitor pops and compares them.
module tb_axi_slave_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr, araddr, wdata, rdata, rdata_be, other_addr, other_wdata;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [15:0] awid, arid, bid, rid;
    logic [3:0]  wstrb, other_strb;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, arvalid, arready;
    logic rlast, rvalid, rready, other_write, other_valid, other_ready, other_error;

    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; logic wr; } bk_t;
    typedef struct { logic [15:0] id; logic [1:0] resp; } b_t;
    typedef struct { logic [31:0] data; logic [15:0] id; logic [1:0] resp; logic last; } r_t;
    bk_t bk_q[$];
    b_t  b_q[$];
    r_t  r_q[$];
    bk_t mon_e;

    int vectors = 0, miscompares = 0;
    int bk_cnt = 0, b_done = 0, r_done = 0;
    int err_abs = 0;
    bit err_en = 1'b0;
    logic [143:0] all_outs;

    always #5 clk = ~clk;

    axi_slave_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(16)) dut (
        .axi_clk_in(clk), .axi_rst_in(rst),
        .axi_awaddr_in(awaddr), .axi_awburst_in(awburst), .axi_awlen_in(awlen),
        .axi_awsize_in(awsize), .axi_awid_in(awid), .axi_awvalid_in(awvalid),
        .axi_awready_out(awready),
        .axi_wdata_in(wdata), .axi_wstrb_in(wstrb), .axi_wlast_in(wlast),
        .axi_wvalid_in(wvalid), .axi_wready_out(wready),
        .axi_bid_out(bid), .axi_bresp_out(bresp), .axi_bvalid_out(bvalid), .axi_bready_in(bready),
        .axi_araddr_in(araddr), .axi_arburst_in(arburst), .axi_arlen_in(arlen),
        .axi_arsize_in(arsize), .axi_arid_in(arid), .axi_arvalid_in(arvalid),
        .axi_arready_out(arready),
        .axi_rdata_out(rdata), .axi_rid_out(rid), .axi_rresp_out(rresp), .axi_rlast_out(rlast),
        .axi_rvalid_out(rvalid), .axi_rready_in(rready),
        .other_addr_out(other_addr), .other_write_out(other_write), .other_wdata_out(other_wdata),
        .other_strb_out(other_strb), .other_valid_out(other_valid), .other_ready_in(other_ready),
        .other_rdata_in(rdata_be), .other_error_in(other_error)
    );

    // Backend model: read data is the address plus one; error on a chosen handshake
    assign rdata_be    = other_addr + 32'd1;
    assign other_error = err_en && (bk_cnt == err_abs);
    assign all_outs = {awready, wready, bid, bresp, bvalid, arready, rdata, rid, rresp, rlast,
                       rvalid, other_addr, other_write, other_wdata, other_strb, other_valid};

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit ref_illegal(input int burst, input int len, input int size);
        return (burst == 3) || ((1 << size) > 4) ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    // Beat address from first principles: FIXED repeats, INCR steps, WRAP stays in its window
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                              input int burst, input int i);
        logic [31:0] bytes, total, base, off;
        bytes = 32'd1 << size;
        total = 32'(len + 1) * bytes;
        case (burst)
            1: return a + 32'(i) * bytes;
            2: begin
                base = (a / total) * total;
                off  = (a - base + 32'(i) * bytes) % total;
                return base + off;
            end
            default: return a;
        endcase
    endfunction

    // Random master/backend ready pressure
    always @(posedge clk) begin
        #1;
        bready      = ($urandom_range(0, 2) != 0);
        rready      = ($urandom_range(0, 2) != 0);
        other_ready = ($urandom_range(0, 3) != 0);
    end

    always @(posedge clk) begin
        if (!rst && other_valid && other_ready) bk_cnt <= bk_cnt + 1;
    end

    // Monitor: compare whatever the DUT presents against the front of each queue
    always @(negedge clk) begin
        if (!rst) begin
            if (other_valid && other_ready) begin
                if (bk_q.size() == 0) chk("bk_unexpected", 160'(bk_q.size()), 160'd1);
                else begin
                    mon_e = bk_q.pop_front();
                    chk("bk_write", 160'(other_write), 160'(mon_e.wr));
                    chk("bk_addr", 160'(other_addr), 160'(mon_e.addr));
                    if (mon_e.wr) begin
                        chk("bk_wdata", 160'(other_wdata), 160'(mon_e.data));
                        chk("bk_strb", 160'(other_strb), 160'(mon_e.strb));
                    end
                end
            end
            if (bvalid) begin
                if (b_q.size() == 0) chk("b_unexpected", 160'(b_q.size()), 160'd1);
                else begin
                    chk("bid", 160'(bid), 160'(b_q[0].id));
                    chk("bresp", 160'(bresp), 160'(b_q[0].resp));
                    if (bready) begin
                        b_q.delete(0);
                        b_done++;
                    end
                end
            end
            if (rvalid) begin
                if (r_q.size() == 0) chk("r_unexpected", 160'(r_q.size()), 160'd1);
                else begin
                    chk("rdata", 160'(rdata), 160'(r_q[0].data));
                    chk("rid", 160'(rid), 160'(r_q[0].id));
                    chk("rresp", 160'(rresp), 160'(r_q[0].resp));
                    chk("rlast", 160'(rlast), 160'(r_q[0].last));
                    if (rready) begin
                        r_q.delete(0);
                        r_done++;
                    end
                end
            end
        end
    end

    task automatic write_burst(input logic [15:0] id, input logic [31:0] addr, input int len,
                               input int size, input int burst, input int err_beat,
                               input int wlast_bad, input logic [31:0] wd_seed, input bit arb);
        bit ill;
        int t, tgt;
        bk_t e;
        b_t eb;
        logic [31:0] d;
        logic [3:0] s;
        ill = ref_illegal(burst, len, size);
        eb.id = id;
        eb.resp = (ill || err_beat >= 0 || wlast_bad >= 0) ? 2'b10 : 2'b00;
        b_q.push_back(eb);
        tgt = b_done + 1;
        err_abs = bk_cnt + err_beat;
        err_en = (err_beat >= 0);
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        if (arb) arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!awready && t < 100);
        chk("aw_handshake", 160'(awready), 160'd1);
        if (arb) chk("arb_ar_blocked", 160'(arready), 160'd0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge clk); #1;
            end
            d = (wd_seed != 32'd0) ? wd_seed + 32'(i) : $urandom;
            s = 4'($urandom);
            if (!ill) begin
                e.addr = beat_addr(addr, len, size, burst, i);
                e.data = d; e.strb = s; e.wr = 1'b1;
                bk_q.push_back(e);
            end
            wdata = d; wstrb = s; wlast = (i == len) ^ (i == wlast_bad); wvalid = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!wready && t < 100);
            chk("w_handshake", 160'(wready), 160'd1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge clk);
        chk("b_latency", 160'(bvalid), 160'd1);
        t = 0;
        while (b_done < tgt && t < 200) begin @(negedge clk); t++; end
        chk("b_complete", 160'(b_done >= tgt), 160'd1);
        err_en = 1'b0;
    endtask

    task automatic read_burst(input logic [15:0] id, input logic [31:0] addr, input int len,
                              input int size, input int burst, input int err_beat,
                              input int rst_after, input bit ar_already);
        bit ill;
        int t, base;
        r_t er;
        bk_t e;
        ill = ref_illegal(burst, len, size);
        base = r_done;
        for (int i = 0; i <= len; i++) begin
            e.addr = beat_addr(addr, len, size, burst, i);
            e.data = 32'd0; e.strb = 4'd0; e.wr = 1'b0;
            er.data = ill ? 32'd0 : e.addr + 32'd1;
            er.id = id;
            er.resp = (ill || i == err_beat) ? 2'b10 : 2'b00;
            er.last = (i == len);
            r_q.push_back(er);
            if (!ill) bk_q.push_back(e);
        end
        err_abs = bk_cnt + err_beat;
        err_en = (err_beat >= 0);
        t = 0;
        if (!ar_already) begin
            @(posedge clk); #1;
            arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
            arvalid = 1'b1;
            do begin @(negedge clk); t++; end while (!arready && t < 100);
        end else begin
            while (!arready && t < 100) begin @(negedge clk); t++; end
        end
        chk("ar_handshake", 160'(arready), 160'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        t = 0;
        if (rst_after >= 0) begin
            while (r_done < base + rst_after && t < 500) begin @(negedge clk); t++; end
            chk("r_before_reset", 160'(r_done >= base + rst_after), 160'd1);
            @(posedge clk); #3;
            rst = 1'b1;
            #1;
            chk("reset_mid_burst_outputs", 160'(all_outs), 160'd0);
            bk_q.delete(); r_q.delete(); b_q.delete();
            @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            while (r_done < base + len + 1 && t < 2000) begin @(negedge clk); t++; end
            chk("r_complete", 160'(r_done - base), 160'(len + 1));
        end
        err_en = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int burst, len, size, eb, wb;
        awaddr = 32'd0; awburst = 2'd0; awlen = 8'd0; awsize = 3'd0; awid = 16'd0; awvalid = 1'b0;
        araddr = 32'd0; arburst = 2'd0; arlen = 8'd0; arsize = 3'd0; arid = 16'd0; arvalid = 1'b0;
        wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0; rready = 1'b0; other_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 160'(all_outs), 160'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Both address channels valid out of reset: write wins, read follows
        arid = 16'd9; araddr = 32'h200; arlen = 8'd3; arsize = 3'd2; arburst = 2'd1;
        write_burst(16'd5, 32'h100, 0, 2, 1, -1, -1, 32'hDEADBEEF, 1'b1);
        read_burst(16'd9, 32'h200, 3, 2, 1, -1, -1, 1'b1);

        write_burst(16'h11, 32'h1C, 3, 2, 2, -1, -1, 32'd0, 1'b0);
        write_burst(16'h12, 32'h1C, 2, 2, 2, -1, -1, 32'd0, 1'b0);
        write_burst(16'h13, 32'h400, 3, 2, 1, 2, -1, 32'd0, 1'b0);
        write_burst(16'h14, 32'h500, 1, 2, 1, -1, 0, 32'd0, 1'b0);
        read_burst(16'h15, 32'h600, 3, 2, 1, 1, -1, 1'b0);
        read_burst(16'h16, 32'h700, 3, 2, 1, -1, 1, 1'b0);
        read_burst(16'h17, 32'h800, 2, 2, 1, -1, -1, 1'b0);
        read_burst(16'h18, 32'h900, 1, 3, 1, -1, -1, 1'b0);
        write_burst(16'h19, 32'hFFFF_FF00, 255, 2, 1, -1, -1, 32'd0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: burst = 0;
                5, 6: burst = 2;
                7: burst = 3;
                default: burst = 1;
            endcase
            size = ($urandom_range(0, 4) == 0) ? 3 : $urandom_range(0, 2);
            if (burst == 2) begin
                case ($urandom_range(0, 4))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    3: len = 15;
                    default: len = 2;
                endcase
            end else begin
                len = $urandom_range(0, 7);
            end
            eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
            wb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
            if ($urandom_range(0, 1) == 0)
                write_burst(16'($urandom), $urandom, len, size, burst, eb, wb, 32'd0, 1'b0);
            else
                read_burst(16'($urandom), $urandom, len, size, burst, eb, -1, 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("bk_queue_drained", 160'(bk_q.size()), 160'd0);
        chk("b_queue_drained", 160'(b_q.size()), 160'd0);
        chk("r_queue_drained", 160'(r_q.size()), 160'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_slave_if.md
# axi_slave_if

AXI responder (slave) interface that terminates AXI write and read bursts from an AXI master and converts each beat into a single-word access on a simple "other module" backend port. It handles one burst at a time, covering address, write-data, write-response and read-data channels. It sits between the AXI interconnect and a register bank or on-chip memory. It generates FIXED/INCR/WRAP beat addresses and reports protocol or backend errors as SLVERR.

## Interface
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 32, data width (32/64/128); NB = AXI_DATA_WIDTH/8
- AXI_ID_WIDTH, 16, ID width
- axi_clk_in  in  1  clock; all logic on rising edge
- axi_rst_in  in  1  reset, asynchronous, active-high
- axi_awaddr_in / axi_awburst_in / axi_awlen_in / axi_awsize_in / axi_awid_in  in  ADDR/2/8/3/ID  write address
- axi_awvalid_in  in  1;  axi_awready_out  out  1
- axi_wdata_in  in  DATA;  axi_wstrb_in  in  NB;  axi_wlast_in  in  1;  axi_wvalid_in  in  1;  axi_wready_out  out  1
- axi_bid_out  out  ID;  axi_bresp_out  out  2;  axi_bvalid_out  out  1;  axi_bready_in  in  1
- axi_araddr_in / axi_arburst_in / axi_arlen_in / axi_arsize_in / axi_arid_in  in  ADDR/2/8/3/ID  read address
- axi_arvalid_in  in  1;  axi_arready_out  out  1
- axi_rdata_out  out  DATA;  axi_rid_out  out  ID;  axi_rresp_out  out  2;  axi_rlast_out  out  1;  axi_rvalid_out  out  1;  axi_rready_in  in  1
- other_addr_out  out  ADDR  beat address
- other_write_out  out  1  1=write, 0=read
- other_wdata_out  out  DATA;  other_strb_out  out  NB
- other_valid_out  out  1  backend request
- other_ready_in  in  1  backend accepts; for reads, other_rdata_in is valid in the same cycle
- other_rdata_in  in  DATA;  other_error_in  in  1  backend error, qualified by other_ready_in

## Operation
- One-hot FSM states:
  - IDLE
  - WDATA
  - BRESP
  - RADDR
  - RDATA
- IDLE arbitration:
  - axi_awready_out = awvalid && (!arvalid || prio_w).
  - axi_arready_out = arvalid && (!awvalid || !prio_w).
  - prio_w resets to 1 and toggles after each accepted address (round-robin).
- On address handshake, capture id, addr, len, size and burst.
  - Clear the beat counter and sticky error.
  - Write goes to WDATA; read goes to RADDR.
- Illegal request, which forces SLVERR for the whole burst and suppresses the backend (other_valid_out stays 0):
  - burst == 3, or
  - (1<<size) > NB, or
  - WRAP with len not in {1,3,7,15}.
  - Beats still complete on the AXI side: wready_out=1, and read data=0.
- WDATA:
  - other_valid_out = wvalid (legal burst).
  - axi_wready_out = other_ready_in (1 if illegal).
  - Address, wdata and strb pass through combinationally.
  - A beat completes on wvalid && wready. Then the counter increments and the address advances.
  - Sticky error |= other_error_in.
  - wlast must equal (count == len); a mismatch sets the sticky error.
  - Leave WDATA after beat len+1 regardless of wlast.
- BRESP:
  - bvalid=1, bid=captured id, bresp = error ? 2'b10 : 2'b00.
  - Held until bready, then IDLE.
- RADDR:
  - other_valid_out=1, other_write_out=0.
  - On other_ready_in, register rdata and resp (other_error_in → 2'b10), set rid and rlast=(count==len), rvalid=1, go to RDATA.
- RDATA:
  - Hold all R outputs until rready.
  - Then clear rvalid and advance the address.
  - If rlast, go to IDLE; else go to RADDR.
- Address generation (ADDR-bit modulo), with bytes = 1<<size:
  - FIXED: unchanged.
  - INCR: addr+bytes.
  - WRAP: mask = (len+1)*bytes-1; next = (addr & ~mask) | ((addr+bytes) & mask).

## Timing
- Reset values:
  - All outputs 0; bresp/rresp = 00.
  - prio_w=1, state IDLE.
- awready/arready are combinational from state and valids, asserted only in IDLE. The address is accepted in the same cycle and the next cycle is WDATA/RADDR.
- Write beat: zero added latency, with wready equal to other_ready_in in the same cycle.
- Read beat: request cycle → backend ready edge → rvalid next cycle. Minimum 2 cycles/beat.
- bvalid asserts the cycle after the last W beat completes.
- A new address is not accepted until BRESP completes or the last R beat is taken.
- Simultaneous awvalid and arvalid in IDLE: exactly one is accepted, per prio_w.
- Reset mid-burst: immediately return to IDLE with all outputs 0. The pending burst is abandoned.
- len=255 INCR: 256 beats, 8-bit counter without overflow. Crossing 4KB is not checked.

## Test plan
- Single write: aw addr 0x100, len 0, size 2, INCR, id 5; wdata 0xDEADBEEF with wlast. → One backend write to 0x100, then B id 5 / OKAY one cycle after the beat.
- INCR read: addr 0x200, len 3, size 2, backend returns addr+1. → R beats 0x201/0x205/0x209/0x20D, rlast only on the 4th. With rready toggling, data stays held while stalled.
- WRAP write: addr 0x1C, len 3, size 2. → Backend addresses 0x1C, 0x10, 0x14, 0x18. Then WRAP with len 2 → no backend writes, 3 beats accepted, bresp SLVERR.
- Error paths: other_error_in on beat 2 of a 4-beat write → bresp 10. wlast asserted on beat 1 of len 1 (too early) → bresp 10. Read error on beat 1 → rresp 10 on that beat only.
- Arbitration: aw and ar both valid from reset → write accepted first; with both still valid afterwards, the read is accepted next.
- Reset asserted during beat 2 of a read → all outputs 0 asynchronously. After release, a fresh read completes normally.
